// File: rtl/iter_alu.sv
// Multi-cycle ALU: logic/arithmetic ops finish in one cycle, shifts move one bit per cycle.
// Operands are captured on start in IDLE; Result and Zero are registered and hold until the next completion.
module iter_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  Control_in,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        Zero,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  op;
    logic [31:0] work;
    logic [4:0]  count;

    logic        is_shift;
    logic [31:0] alu_out;
    logic [31:0] idle_result;
    logic [31:0] shift_next;

    assign state_dbg = state;

    // Handshake: start is a request accepted only while busy=0 (IDLE); there is no
    // back-pressure on the result, done is a single-cycle valid with Result/Zero.
    always_comb begin
        is_shift = (Control_in == OP_SLL) || (Control_in == OP_SRL) ||
                   (Control_in == OP_SRA);
    end

    always_comb begin
        alu_out = 32'd0;
        case (Control_in)
            OP_AND:  alu_out = A & B;
            OP_OR:   alu_out = A | B;
            OP_ADD:  alu_out = A + B;
            OP_SUB:  alu_out = A - B;
            OP_XOR:  alu_out = A ^ B;
            OP_SLT:  alu_out = {31'd0, ($signed(A) < $signed(B))};
            OP_SLTU: alu_out = {31'd0, (A < B)};
            default: alu_out = 32'd0;
        endcase
    end

    // A shift with zero amount passes A straight through on the fast path.
    always_comb begin
        idle_result = is_shift ? A : alu_out;
    end

    always_comb begin
        shift_next = work;
        case (op)
            OP_SLL:  shift_next = {work[30:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, work[31:1]};
            OP_SRA:  shift_next = {work[31], work[31:1]};
            default: shift_next = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= 32'd0;
            Zero   <= 1'b1;
            count  <= 5'd0;
            op     <= 4'd0;
            work   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op   <= Control_in;
                        busy <= 1'b1;
                        if (is_shift && (B[4:0] != 5'd0)) begin
                            work  <= A;
                            count <= B[4:0];
                            state <= SHIFT;
                        end else begin
                            Result <= idle_result;
                            Zero   <= (idle_result == 32'd0);
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work  <= shift_next;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        Result <= shift_next;
                        Zero   <= (shift_next == 32'd0);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
